cdb_broadcaster: RTL and testbench

Writeback-side transmitter for the common data bus. Collects finished results (value + ROB tag) from up to four functional units, buffers each in a small per-unit FIFO, arbitrates, and drives one registered broadcast per cycle onto the CDB. The ALU reservation station entries and the ROB snoop this broadcast to wake operands and mark completion. Sits between functional-unit outputs and the `commonDataBus` interface.

---
 rtl/cdb_broadcaster.sv | 155 +++++++++++++++
 tb/tb_cdb_broadcaster.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcaster.sv
// Common-data-bus transmitter: per-source result FIFOs, arbitration and one registered broadcast per cycle.
// Optional macro CDB_ROUND_ROBIN_EN selects rotating priority; otherwise lowest source index wins.
module cdb_broadcaster #(
    parameter int WIDTH = 31,
    parameter int ROB   = 2,
    parameter int FU    = 3,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   clear,
    input  logic [FU:0]            resultValid,
    input  logic [FU:0][WIDTH:0]   resultValue,
    input  logic [FU:0][ROB:0]     resultRob,
    output logic [FU:0]            resultReady,
    output logic                   cdbValid,
    output logic signed [WIDTH:0]  cdbValue,
    output logic [ROB:0]           cdbRob
);

    localparam int NS = FU + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    logic [CW-1:0]  cnt_r     [NS];
    logic [PW-1:0]  head_r    [NS];
    logic [PW-1:0]  tail_r    [NS];
    logic [WIDTH:0] val_mem_r [NS][DEPTH];
    logic [ROB:0]   rob_mem_r [NS][DEPTH];

    logic [FU:0]    push_s;
    logic [FU:0]    pop_s;
    logic           grant_s;
    logic [SW-1:0]  winner_s;

    // Ready depends only on the registered count, so a same-cycle pop never raises it
    always_comb begin
        resultReady = {NS{1'b0}};
        push_s      = {NS{1'b0}};
        pop_s       = {NS{1'b0}};
        for (int i = 0; i < NS; i++) begin
            resultReady[i] = (cnt_r[i] < CW'(DEPTH));
            push_s[i]      = resultValid[i] & resultReady[i];
            pop_s[i]       = grant_s & (winner_s == SW'(i));
        end
    end

`ifdef CDB_ROUND_ROBIN_EN
    logic [SW-1:0] last_grant_r;
    logic [SW-1:0] cand_s;

    // Rotating search starting one past the previous winner
    always_comb begin
        grant_s  = 1'b0;
        winner_s = SW'(0);
        cand_s   = SW'(0);
        for (int k = 1; k <= NS; k++) begin
            cand_s = SW'((int'(last_grant_r) + k) % NS);
            if (!grant_s && (cnt_r[cand_s] != CW'(0))) begin
                grant_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Remember the last winner; only moves when a grant is issued
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            last_grant_r <= SW'(FU);
        end else if (clear) begin
            last_grant_r <= SW'(FU);
        end else if (grant_s) begin
            last_grant_r <= winner_s;
        end
    end
`else
    // Fixed priority: lowest-indexed non-empty FIFO wins
    always_comb begin
        grant_s  = 1'b0;
        winner_s = SW'(0);
        for (int i = 0; i < NS; i++) begin
            if (!grant_s && (cnt_r[i] != CW'(0))) begin
                grant_s  = 1'b1;
                winner_s = SW'(i);
            end else begin
                winner_s = winner_s;
            end
        end
    end
`endif

    // FIFO bookkeeping; count is kept separately so full and empty never alias
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NS; i++) begin
                cnt_r[i]  <= CW'(0);
                head_r[i] <= PW'(0);
                tail_r[i] <= PW'(0);
            end
        end else if (clear) begin
            for (int i = 0; i < NS; i++) begin
                cnt_r[i]  <= CW'(0);
                head_r[i] <= PW'(0);
                tail_r[i] <= PW'(0);
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (push_s[i]) begin
                    tail_r[i] <= tail_r[i] + PW'(1);
                end
                if (pop_s[i]) begin
                    head_r[i] <= head_r[i] + PW'(1);
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CW'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CW'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Result storage; stale slots are harmless because the count gates every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (push_s[i]) begin
                val_mem_r[i][tail_r[i]] <= resultValue[i];
                rob_mem_r[i][tail_r[i]] <= resultRob[i];
            end
        end
    end

    // Broadcast register; value and tag hold when nothing is granted
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cdbValid <= 1'b0;
            cdbValue <= '0;
            cdbRob   <= '0;
        end else if (clear) begin
            cdbValid <= 1'b0;
            cdbValue <= '0;
            cdbRob   <= '0;
        end else if (grant_s) begin
            cdbValid <= 1'b1;
            cdbValue <= val_mem_r[winner_s][head_r[winner_s]];
            cdbRob   <= rob_mem_r[winner_s][head_r[winner_s]];
        end else begin
            cdbValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Randomized bench for cdb_broadcaster: queue-based reference model compared every cycle, plus literal scenario checks.
module tb_cdb_broadcaster;

    localparam int NS    = 4;
    localparam int DEPTH = 2;

    logic               clk = 1'b0;
    logic               resetN;
    logic               clear;
    logic [3:0]         resultValid;
    logic [3:0][31:0]   resultValue;
    logic [3:0][2:0]    resultRob;
    logic [3:0]         resultReady;
    logic               cdbValid;
    logic signed [31:0] cdbValue;
    logic [2:0]         cdbRob;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    typedef struct {
        logic [31:0] v;
        logic [2:0]  r;
    } ent_t;

    ent_t        q [NS][$];
    int          m_last;
    logic        m_valid;
    logic [31:0] m_val;
    logic [2:0]  m_rob;

    always #5 clk = ~clk;

    cdb_broadcaster #(.WIDTH(31), .ROB(2), .FU(3), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetN(resetN), .clear(clear),
        .resultValid(resultValid), .resultValue(resultValue), .resultRob(resultRob),
        .resultReady(resultReady),
        .cdbValid(cdbValid), .cdbValue(cdbValue), .cdbRob(cdbRob)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) q[i].delete();
        m_last  = NS - 1;
        m_valid = 1'b0;
        m_val   = 32'h0;
        m_rob   = 3'h0;
    endtask

    // One clock edge of the reference: pick a winner from the queues, pop it, then accept offers
    task automatic model_step();
        bit   rdy [NS];
        int   w;
        ent_t e;
        if (!resetN || clear) begin
            model_reset();
        end else begin
            for (int i = 0; i < NS; i++) rdy[i] = (q[i].size() < DEPTH);
            w = -1;
`ifdef CDB_ROUND_ROBIN_EN
            for (int k = 1; k <= NS; k++) begin
                int s;
                s = (m_last + k) % NS;
                if (w < 0 && q[s].size() > 0) w = s;
            end
`else
            for (int i = 0; i < NS; i++) begin
                if (w < 0 && q[i].size() > 0) w = i;
            end
`endif
            if (w >= 0) begin
                e       = q[w].pop_front();
                m_valid = 1'b1;
                m_val   = e.v;
                m_rob   = e.r;
                m_last  = w;
            end else begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < NS; i++) begin
                if (resultValid[i] && rdy[i]) begin
                    e.v = resultValue[i];
                    e.r = resultRob[i];
                    q[i].push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Per-cycle comparison against the reference model
    always @(negedge clk) begin
        if (started) begin
            check("cdb_valid", {63'h0, cdbValid}, {63'h0, m_valid});
            if (m_valid) begin
                check("cdb_value", {32'h0, cdbValue}, {32'h0, m_val});
                check("cdb_rob", {61'h0, cdbRob}, {61'h0, m_rob});
            end
            for (int i = 0; i < NS; i++)
                check($sformatf("ready%0d", i), {63'h0, resultReady[i]},
                      {63'h0, (q[i].size() < DEPTH)});
        end
    end

    initial begin
        logic [3:0] pr;
        resetN = 1'b0;
        clear = 1'b0;
        resultValid = 4'h0;
        resultValue = '0;
        resultRob = '0;
        model_reset();
        #12;
        check("rst_valid", {63'h0, cdbValid}, 64'h0);
        check("rst_value", {32'h0, cdbValue}, 64'h0);
        check("rst_rob", {61'h0, cdbRob}, 64'h0);
        check("rst_ready", {60'h0, resultReady}, 64'hf);
        resetN = 1'b1;
        started = 1'b1;
        tick();

        // single result
        resultValid = 4'b0001;
        resultValue[0] = 32'h12345678;
        resultRob[0] = 3'd3;
        tick();
        resultValid = 4'h0;
        check("single_pre", {63'h0, cdbValid}, 64'h0);
        tick();
        check("single_valid", {63'h0, cdbValid}, 64'h1);
        check("single_value", {32'h0, cdbValue}, 64'h12345678);
        check("single_rob", {61'h0, cdbRob}, 64'h3);
        tick();
        check("single_post", {63'h0, cdbValid}, 64'h0);

        // four-way collision
        clear_pulse();
        for (int i = 0; i < NS; i++) begin
            resultValue[i] = $urandom;
            resultRob[i] = 3'(i);
        end
        resultValid = 4'hf;
        tick();
        resultValid = 4'h0;
        for (int k = 0; k < NS; k++) begin
            tick();
            check("coll_valid", {63'h0, cdbValid}, 64'h1);
            check("coll_rob", {61'h0, cdbRob}, 64'(k));
        end
        tick();

        // back-pressure with two continuous sources
        clear_pulse();
        resultRob[0] = 3'd0;
        resultRob[1] = 3'd1;
        resultValue[0] = 32'h0000_0000;
        resultValue[1] = 32'h0001_0000;
        resultValid = 4'b0011;
        for (int c = 0; c < 16; c++) begin
            pr = resultReady;
            tick();
            for (int s = 0; s < 2; s++)
                if (pr[s]) resultValue[s] = resultValue[s] + 32'd1;
            if (c >= 1) begin
                check("bp_valid", {63'h0, cdbValid}, 64'h1);
`ifdef CDB_ROUND_ROBIN_EN
                check("bp_alternate", {61'h0, cdbRob}, 64'((c - 1) % 2));
`else
                check("bp_fixed", {61'h0, cdbRob}, 64'h0);
`endif
            end
        end
        resultValid = 4'h0;
        for (int c = 0; c < 8; c++) tick();

        // flush with three held entries and a push in the clear cycle
        for (int i = 0; i < 3; i++) begin
            resultValue[i] = 32'hF1A5_0000 + 32'(i);
            resultRob[i] = 3'(i);
        end
        resultValid = 4'b0111;
        tick();
        resultValid = 4'b0100;
        resultValue[2] = 32'hF1A5_0099;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        resultValid = 4'h0;
        check("flush_valid", {63'h0, cdbValid}, 64'h0);
        check("flush_ready", {60'h0, resultReady}, 64'hf);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("flush_quiet", {63'h0, cdbValid}, 64'h0);
        end

        // asynchronous reset while broadcasting
        resultValid = 4'b0110;
        resultValue[1] = 32'hAAAA_0001;
        resultValue[2] = 32'hAAAA_0002;
        resultRob[1] = 3'd1;
        resultRob[2] = 3'd2;
        tick();
        resultValid = 4'h0;
        tick();
        check("areset_pre", {63'h0, cdbValid}, 64'h1);
        #1;
        resetN = 1'b0;
        model_reset();
        #1;
        check("areset_valid", {63'h0, cdbValid}, 64'h0);
        check("areset_value", {32'h0, cdbValue}, 64'h0);
        check("areset_ready", {60'h0, resultReady}, 64'hf);
        @(negedge clk);
        resetN = 1'b1;
        resultValid = 4'b0011;
        resultValue[0] = 32'hBBBB_0000;
        resultValue[1] = 32'hBBBB_0001;
        resultRob[0] = 3'd6;
        resultRob[1] = 3'd5;
        tick();
        resultValid = 4'h0;
        tick();
        check("areset_first", {61'h0, cdbRob}, 64'h6);
        for (int c = 0; c < 3; c++) tick();

`ifndef CDB_ROUND_ROBIN_EN
        // fixed priority starvation of source 3
        clear_pulse();
        resultRob[0] = 3'd0;
        resultRob[3] = 3'd3;
        resultValid = 4'b1001;
        for (int c = 0; c < 12; c++) begin
            pr = resultReady;
            tick();
            if (pr[0]) resultValue[0] = resultValue[0] + 32'd1;
            if (pr[3]) resultValue[3] = resultValue[3] + 32'd1;
            if (c >= 1) begin
                check("starve_rob", {61'h0, cdbRob}, 64'h0);
                check("starve_ready3", {63'h0, resultReady[3]}, 64'h0);
            end
        end
        resultValid = 4'h0;
        for (int c = 0; c < 8; c++) tick();
`endif

        // randomized traffic with occasional flushes
        for (int c = 0; c < 1500; c++) begin
            resultValid = 4'($urandom);
            for (int i = 0; i < NS; i++) begin
                resultValue[i] = $urandom;
                resultRob[i] = 3'($urandom);
            end
            clear = ($urandom_range(0, 40) == 0);
            tick();
        end
        clear = 1'b0;
        resultValid = 4'h0;
        for (int c = 0; c < 10; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
